// File: rtl/operand_fetch_if.sv
// Operand fetch bus: decoded-instruction input, ALU operand output, writeback and scoreboard view.
// The DUT uses the slave modport; the issuing/consuming side uses master.
interface operand_fetch_if #(
    parameter int W   = 8,
    parameter int Ops = 4,
    parameter int RA  = 3
);
    logic              InValid;
    logic              InReady;
    logic [Ops-1:0]    InOP;
    logic [RA-1:0]     InSrcA;
    logic [RA-1:0]     InSrcB;
    logic              InUseImm;
    logic [W-1:0]      InImm;
    logic [RA-1:0]     InDst;
    logic              InWrEn;
    logic              OutValid;
    logic              OutReady;
    logic [W-1:0]      InputA;
    logic [W-1:0]      InputB;
    logic [Ops-1:0]    OP;
    logic [RA-1:0]     OutDst;
    logic              OutWrEn;
    logic              WbEn;
    logic [RA-1:0]     WbAddr;
    logic [W-1:0]      WbData;
    logic [(1<<RA)-1:0] Busy;

    modport master (
        output InValid, InOP, InSrcA, InSrcB, InUseImm, InImm, InDst, InWrEn,
        output OutReady, WbEn, WbAddr, WbData,
        input  InReady, OutValid, InputA, InputB, OP, OutDst, OutWrEn, Busy
    );

    modport slave (
        input  InValid, InOP, InSrcA, InSrcB, InUseImm, InImm, InDst, InWrEn,
        input  OutReady, WbEn, WbAddr, WbData,
        output InReady, OutValid, InputA, InputB, OP, OutDst, OutWrEn, Busy
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file + per-register scoreboard feeding a registered ALU operand stage.
// Define OPFETCH_BYPASS_EN to forward same-cycle writebacks into reads and hazard release.

module operand_fetch_entry #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         set,
    output logic [W-1:0] data,
    output logic         busy
);
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            if (wr) data <= wdata;
            // an issue claiming this register outranks a writeback releasing it
            if (set)     busy <= 1'b1;
            else if (wr) busy <= 1'b0;
        end
    end
endmodule

module operand_fetch #(
    parameter int W   = 8,
    parameter int Ops = 4,
    parameter int RA  = 3
) (
    input logic             Clk,
    input logic             Reset,
    operand_fetch_if.slave  bus
);
    localparam int N = 1 << RA;

    logic [N-1:0][W-1:0] regs;
    logic [N-1:0]        busy, wb_hit, set_bit, pend;
    logic                hazard, accept, in_ready;
    logic [W-1:0]        opa, opb;

    logic                out_vld, out_wr;
    logic [W-1:0]        out_a, out_b;
    logic [Ops-1:0]      out_op;
    logic [RA-1:0]       out_dst;

    assign accept = bus.InValid && in_ready;

    for (genvar i = 0; i < N; i++) begin : g_ent
        assign wb_hit[i]  = bus.WbEn && (bus.WbAddr == RA'(i));
        assign set_bit[i] = accept && bus.InWrEn && (bus.InDst == RA'(i));
`ifdef OPFETCH_BYPASS_EN
        assign pend[i] = busy[i] && !wb_hit[i];
`else
        assign pend[i] = busy[i];
`endif
        operand_fetch_entry #(.W(W)) u_ent (
            .Clk   (Clk),
            .Reset (Reset),
            .wr    (wb_hit[i]),
            .wdata (bus.WbData),
            .set   (set_bit[i]),
            .data  (regs[i]),
            .busy  (busy[i])
        );
    end

    assign hazard   = pend[bus.InSrcA]
                    | (!bus.InUseImm && pend[bus.InSrcB])
                    | (bus.InWrEn && pend[bus.InDst]);
    assign in_ready = !hazard && (!out_vld || bus.OutReady);

    always_comb begin
        opa = regs[bus.InSrcA];
        opb = regs[bus.InSrcB];
`ifdef OPFETCH_BYPASS_EN
        if (bus.WbEn && bus.WbAddr == bus.InSrcA) opa = bus.WbData;
        if (bus.WbEn && bus.WbAddr == bus.InSrcB) opb = bus.WbData;
`endif
        if (bus.InUseImm) opb = bus.InImm;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_vld <= 1'b0;
            out_wr  <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
            out_op  <= '0;
            out_dst <= '0;
        end else if (accept) begin
            out_vld <= 1'b1;
            out_wr  <= bus.InWrEn;
            out_a   <= opa;
            out_b   <= opb;
            out_op  <= bus.InOP;
            out_dst <= bus.InDst;
        end else if (out_vld && bus.OutReady) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_vld;
    assign bus.OutWrEn  = out_wr;
    assign bus.InputA   = out_a;
    assign bus.InputB   = out_b;
    assign bus.OP       = out_op;
    assign bus.OutDst   = out_dst;
    assign bus.Busy     = busy;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed issues push expected operands, a negedge monitor pops on transfer.
module tb_operand_fetch;
`ifdef OPFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    operand_fetch_if #(.W(8), .Ops(4), .RA(3)) bus ();
    operand_fetch #(.W(8), .Ops(4), .RA(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [2:0] dst;
        logic       wr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int n;

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                input logic [2:0] dst, input logic wr);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.dst = dst; e.wr = wr;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge Clk); #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb, input logic ui,
                         input logic [7:0] imm, input logic [2:0] dst, input logic we);
        bus.InOP = op; bus.InSrcA = sa; bus.InSrcB = sb; bus.InUseImm = ui;
        bus.InImm = imm; bus.InDst = dst; bus.InWrEn = we; bus.InValid = 1'b1;
    endtask

    // Counts stalled cycles before InReady; returns at the negedge of the accepting cycle.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        @(negedge Clk);
        while (!bus.InReady && cnt < 20) begin
            @(posedge Clk); #1;
            bus.WbEn = 1'b0;
            @(negedge Clk);
            cnt++;
        end
        if (!bus.InReady) chk("ready_timeout", {31'd0, bus.InReady}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb, input logic ui,
                         input logic [7:0] imm, input logic [2:0] dst, input logic we,
                         input exp_t e, input bit push, output int cnt);
        drive(op, sa, sb, ui, imm, dst, we);
        wait_ready(cnt);
        if (push) q.push_back(e);
        sync();
        bus.InValid = 1'b0;
        bus.WbEn = 1'b0;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [7:0] data);
        bus.WbEn = 1'b1; bus.WbAddr = addr; bus.WbData = data;
        sync();
        bus.WbEn = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (!Reset && bus.OutValid && bus.OutReady) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got %0h expected no transfer",
                         {bus.InputA, bus.InputB, bus.OP, bus.OutDst, bus.OutWrEn});
            end else begin
                mon_e = q.pop_front();
                chk("out_data", {8'd0, bus.InputA, bus.InputB, bus.OP, bus.OutDst, bus.OutWrEn}, {8'd0, mon_e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        bus.InValid = 0; bus.InOP = 0; bus.InSrcA = 0; bus.InSrcB = 0; bus.InUseImm = 0;
        bus.InImm = 0; bus.InDst = 0; bus.InWrEn = 0; bus.OutReady = 1;
        bus.WbEn = 0; bus.WbAddr = 0; bus.WbData = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_outvalid", {31'd0, bus.OutValid}, 32'd0);
        chk("rst_busy", {24'd0, bus.Busy}, 32'd0);
        chk("rst_inready", {31'd0, bus.InReady}, 32'd1);
        sync();
        Reset = 1'b0;

        // basic issue with immediate
        wb(3'd3, 8'h5A);
        issue(4'd1, 3'd3, 3'd0, 1, 8'h01, 3'd4, 1, mk(8'h5A, 8'h01, 4'd1, 3'd4, 1), 1, n);
        @(negedge Clk);
        chk("first_outvalid", {31'd0, bus.OutValid}, 32'd1);
        chk("first_busy", {24'd0, bus.Busy}, 32'h10);
        sync();

        // RAW hazard on r2
        issue(4'd2, 3'd0, 3'd1, 0, 8'h00, 3'd2, 1, mk(8'h00, 8'h00, 4'd2, 3'd2, 1), 1, n);
        chk("dst_r2_no_wait", n, 0);
        drive(4'd3, 3'd2, 3'd0, 1, 8'h05, 3'd0, 0);
        repeat (2) begin
            @(negedge Clk);
            chk("raw_stall", {31'd0, bus.InReady}, 32'd0);
            sync();
        end
        bus.WbEn = 1; bus.WbAddr = 3'd2; bus.WbData = 8'h10;
        wait_ready(n);
        chk("raw_release_delay", n, (BYP != 0) ? 0 : 1);
        q.push_back(mk(8'h10, 8'h05, 4'd3, 3'd0, 0));
        sync();
        bus.InValid = 0; bus.WbEn = 0;
        @(negedge Clk);
        chk("busy_after_raw", {24'd0, bus.Busy}, 32'h10);
        sync();

        // backpressure: hold for 3 cycles then back-to-back
        issue(4'd4, 3'd3, 3'd0, 1, 8'h33, 3'd0, 0, mk(8'h5A, 8'h33, 4'd4, 3'd0, 0), 1, n);
        bus.OutReady = 0;
        drive(4'd5, 3'd2, 3'd0, 1, 8'h44, 3'd0, 0);
        repeat (3) begin
            @(negedge Clk);
            chk("hold_ops", {8'd0, bus.InputA, bus.InputB, 4'd0, bus.OP}, {8'd0, 8'h5A, 8'h33, 4'd0, 4'd4});
            chk("hold_ready_valid", {30'd0, bus.InReady, bus.OutValid}, 32'd1);
            sync();
        end
        bus.OutReady = 1;
        q.push_back(mk(8'h10, 8'h44, 4'd5, 3'd0, 0));
        wait_ready(n);
        chk("release_no_wait", n, 0);
        sync();
        bus.InValid = 0;
        @(negedge Clk);
        chk("b2b_valid", {31'd0, bus.OutValid}, 32'd1);
        sync();

        // WAW on r5
        issue(4'd6, 3'd3, 3'd0, 1, 8'h01, 3'd5, 1, mk(8'h5A, 8'h01, 4'd6, 3'd5, 1), 1, n);
        drive(4'd7, 3'd0, 3'd0, 1, 8'h02, 3'd5, 1);
        repeat (2) begin
            @(negedge Clk);
            chk("waw_stall", {31'd0, bus.InReady}, 32'd0);
            sync();
        end
        bus.WbEn = 1; bus.WbAddr = 3'd5; bus.WbData = 8'h99;
        wait_ready(n);
        chk("waw_release_delay", n, (BYP != 0) ? 0 : 1);
        q.push_back(mk(8'h00, 8'h02, 4'd7, 3'd5, 1));
        sync();
        bus.InValid = 0; bus.WbEn = 0;
        @(negedge Clk);
        chk("waw_busy5", {31'd0, bus.Busy[5]}, 32'd1);
        sync();

        // immediate masks a busy SrcB
        issue(4'd8, 3'd0, 3'd0, 1, 8'h00, 3'd6, 1, mk(8'h00, 8'h00, 4'd8, 3'd6, 1), 1, n);
        drive(4'd9, 3'd3, 3'd6, 0, 8'h7F, 3'd0, 0);
        @(negedge Clk);
        chk("srcb_stall", {31'd0, bus.InReady}, 32'd0);
        sync();
        bus.InUseImm = 1;
        wait_ready(n);
        chk("imm_no_stall", n, 0);
        q.push_back(mk(8'h5A, 8'h7F, 4'd9, 3'd0, 0));
        sync();
        bus.InValid = 0;
        @(negedge Clk);
        chk("busy_456", {24'd0, bus.Busy}, 32'h70);
        sync();

        // reset while busy and holding an output
        wb(3'd4, 8'h00);
        wb(3'd5, 8'h99);
        wb(3'd6, 8'h00);
        issue(4'd10, 3'd0, 3'd0, 1, 8'h00, 3'd2, 1, mk(8'h00, 8'h00, 4'd10, 3'd2, 1), 1, n);
        issue(4'd11, 3'd0, 3'd0, 1, 8'h00, 3'd3, 1, mk(8'h00, 8'h00, 4'd11, 3'd3, 1), 0, n);
        bus.OutReady = 0;
        @(negedge Clk);
        chk("pre_rst_busy", {24'd0, bus.Busy}, 32'h0C);
        chk("pre_rst_valid", {31'd0, bus.OutValid}, 32'd1);
        #2 Reset = 1;
        #1;
        chk("rst_busy_async", {24'd0, bus.Busy}, 32'd0);
        chk("rst_outs_async", {2'd0, bus.OutValid, bus.OutWrEn, bus.OutDst, bus.OP, bus.InputA, bus.InputB},
            32'd0);
        sync();
        Reset = 0;
        bus.OutReady = 1;
        issue(4'd1, 3'd3, 3'd5, 0, 8'h00, 3'd0, 0, mk(8'h00, 8'h00, 4'd1, 3'd0, 0), 1, n);
        chk("post_rst_no_wait", n, 0);
        repeat (3) sync();
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the combinational ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file.
- Tracks pending writes with a per-register scoreboard and stalls on hazards.
- Presents registered InputA/InputB/OP to the ALU and accepts the writeback of ALU results.

Parameters:
- W, 8, data width; matches ALU W.
- Ops, 4, opcode width; matches ALU Ops.
- RA, 3, register address width; register file has 2**RA entries.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- InValid  in  1  decoded instruction present.
- InReady  out  1  stage accepts the instruction this cycle.
- InOP  in  Ops  ALU opcode.
- InSrcA  in  RA  source A register.
- InSrcB  in  RA  source B register.
- InUseImm  in  1  1 = B operand is InImm; SrcB ignored.
- InImm  in  W  immediate value.
- InDst  in  RA  destination register.
- InWrEn  in  1  instruction writes InDst.
- OutValid  out  1  ALU operands valid.
- OutReady  in  1  downstream consumes this cycle.
- InputA  out  W  operand A to ALU.
- InputB  out  W  operand B to ALU.
- OP  out  Ops  opcode to ALU.
- OutDst  out  RA  destination, travels with the result.
- OutWrEn  out  1  result must be written back.
- WbEn  in  1  writeback strobe.
- WbAddr  in  RA  writeback register.
- WbData  in  W  writeback value.
- Busy  out  2**RA  scoreboard; bit i = write to register i pending.

Behaviour:
- Reset, asynchronous: all registers = 0, Busy = 0, OutValid = 0, InputA/InputB/OP/OutDst = 0, OutWrEn = 0. Reset mid-operation drops any held instruction. Pending writes are forgotten.
- Register file writes at posedge when WbEn (WbData to WbAddr). All entries are writable.
- Hazard (combinational) is set when any of these pending bits is set:
  - pend[InSrcA];
  - !InUseImm && pend[InSrcB];
  - InWrEn && pend[InDst] (WAW stall; the scoreboard allows one write in flight per register).
- pend[i] definition:
  - With bypass: Busy[i] && !(WbEn && WbAddr==i).
  - Without bypass: Busy[i].
- InReady = !hazard && (!OutValid || OutReady). InReady does not depend on InValid.
- Accept = InValid && InReady. At posedge on accept, the output register loads:
  - InputA = read(SrcA); InputB = InUseImm ? InImm : read(SrcB).
  - OP, OutDst, OutWrEn from the instruction; OutValid = 1.
- Latency: 1 cycle from accept to OutValid.
- If OutValid && OutReady && !accept, OutValid falls to 0. If OutValid && !OutReady, all outputs hold stable.
- Scoreboard:
  - Accept with InWrEn sets Busy[InDst].
  - WbEn clears Busy[WbAddr].
  - Set and clear of the same index in the same cycle: set wins. This covers the bypass case where writeback releases the Dst hazard.
- WbEn to a register with Busy = 0 is legal: data is written and Busy is unchanged.
- Instruction with InWrEn = 0 never touches the scoreboard.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined:
  - read(r) = (WbEn && WbAddr==r) ? WbData : regs[r].
  - A writeback releases the hazard in the same cycle; the dependent instruction is accepted in that cycle.
- Undefined:
  - read(r) = regs[r].
  - The dependent instruction is accepted no earlier than the cycle after WbEn.

Test Plan:
- Reset, then WbEn r3=0x5A, then issue ADD r3,imm 0x01, Dst r4 -> next cycle InputA=0x5A, InputB=0x01, OutValid=1, Busy[4]=1.
- Issue Dst r2 (InWrEn=1), then SUB SrcA=r2 -> InReady=0 until WbEn r2=0x10.
  - Bypass build: accepted in the WbEn cycle with InputA=0x10.
  - Non-bypass build: accepted one cycle later, also InputA=0x10.
- OutReady=0 for 3 cycles with OutValid=1 -> InputA/InputB/OP stable, InReady=0. OutReady=1 -> next instruction loads the following cycle, giving back-to-back OutValid.
- Two instructions both Dst r5 -> second stalls (WAW) until WbEn r5. Busy[5] remains 1 after that writeback because the second instruction's issue sets it (set wins).
- InUseImm=1 with SrcB=r6 busy -> no stall; InputB=InImm=0x7F.
- Assert Reset while OutValid=1 and Busy=0x0C -> outputs immediately 0, Busy=0, register file reads 0.
